mem_responder: RTL
==================

# mem_responder

Memory-side responder for the program-counter address path. Accepts one read or write request at a time on an 8-bit address, inserts a parameterised number of wait states, performs the access on an internal 2^AW x DW storage array, and acknowledges with a single-cycle pulse. Sits between the PC/C-bus address mux and the instruction/data consumers. Models RAM latency so the fetch and execute control can be exercised against realistic timing.

## Interface
- AW, 8, address width; storage depth is 2^AW words
- DW, 16, data word width
- WAIT, 2, wait states inserted per access; legal range 0..15
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- req  input  1  request; held high by the initiator until ack
- write  input  1  1 = write, 0 = read; sampled with req
- address  input  AW  word address; sampled with req
- wdata  input  DW  write data; sampled with req
- rdata  output  DW  read data; valid while ack=1, holds until the next read completes
- ack  output  1  one-cycle completion pulse
- busy  output  1  high whenever state is not IDLE

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: on an edge with req=1, capture address, write and wdata into internal registers. Load the wait counter with WAIT and go to WAIT. With req=0, stay in IDLE.
- WAIT: on each edge with counter > 0, decrement the counter. On an edge with counter = 0, perform the access using the captured fields and go to ACK:
  - write: mem[addr] <= wdata; rdata unchanged.
  - read: rdata <= mem[addr].
- ACK: ack=1 for exactly this cycle. The next edge always returns to IDLE.
- Inputs are ignored outside IDLE. Changes to address, wdata or write during WAIT or ACK do not affect the transaction in flight.
- If req drops during WAIT, the access still completes and ack still pulses. A captured transaction is never aborted except by reset.
- Back-to-back operation: if req is still high in the IDLE cycle after ACK, a new transaction is accepted. The initiator must drop req in the ACK cycle to avoid a duplicate access.
- Storage contents are not cleared by reset; they are undefined until written.
- Address arithmetic is none; the full AW-bit range is valid, and 0 and 2^AW-1 behave identically to any other address.

## Timing
- Reset values (asserted asynchronously): state=IDLE, ack=0, busy=0, rdata=0, wait counter=0, captured registers=0.
- Accepting edge is E. busy goes high after E. ack is high in the cycle following edge E+WAIT+1. The state returns to IDLE after edge E+WAIT+2.
- Minimum transaction period is WAIT+3 cycles (IDLE, WAIT x (WAIT+1), ACK).
- rdata updates on the same edge that raises ack, and holds through later writes and idle cycles.
- Reset asserted mid-transaction: the access is abandoned, with no write committed unless the commit edge has already occurred. ack never pulses for that transaction. The first request accepted is the one sampled on the first edge after reset deasserts.
- A read of an address written by the immediately preceding transaction returns the new data.

## Test plan
- Reset: hold reset=0 while toggling req/address -> ack=0, busy=0, rdata=0 throughout. Release and idle 3 cycles -> outputs unchanged.
- Write then read, WAIT=2: write 0xBEEF to 0x12, then read 0x12 -> each ack occurs 3 cycles after its accepting edge, and the read gives rdata=0xBEEF. rdata stays 0 across the write.
- Boundary addresses: write 0x1111 to 0x00 and 0x2222 to 0xFF, then read both -> 0x1111 and 0x2222, with no aliasing between them.
- Back-to-back with WAIT=0: req held high for 2 reads of pre-written 0x05=0xA5A5 and 0x06=0x5A5A -> ack pulses 3 cycles apart with the correct data. Holding req through ACK produces a duplicate access, which is counted and reported.
- Input churn and req drop: accept a read of 0x40, then change the address to 0x41 and drop req during WAIT -> ack still pulses, and rdata equals mem[0x40].
- Reset mid-op: accept a write of 0xCAFE to 0x30 and assert reset during WAIT (before the commit edge). Release, then read 0x30 -> the old value is returned, and no ack was issued for the aborted write.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the PC/C-bus address path.
// Accepts one read or write at a time, inserts WAIT wait states, performs the
// access on an internal 2^AW x DW array and acknowledges with a one-cycle pulse.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - asynchronous, active-low reset
//   req      - request, held by the initiator until ack
//   write    - 1 = write, 0 = read; sampled with req
//   address  - word address; sampled with req
//   wdata    - write data; sampled with req
//   rdata    - read data; updates on the edge raising ack, holds otherwise
//   ack      - one-cycle completion pulse
//   busy     - high whenever the responder is not idle
module mem_responder #(
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 16,
  parameter int unsigned WAIT = 2   // legal range 0..15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          write,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          busy
);

  localparam int unsigned Depth   = 2 ** AW;
  localparam logic [3:0]  WaitCnt = 4'(WAIT);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            mem_we;

  // Storage is deliberately not reset; contents are undefined until written.
  logic [DW-1:0]   mem_q [Depth];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = address;
          write_d = write;
          wdata_d = wdata;
          cnt_d   = WaitCnt;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Access uses only the captured fields; live inputs are ignored here.
          if (write_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[addr_q];
          end
          state_d = StAck;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // mem_we is decoded from state_q, so an asynchronous reset before the commit
  // edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ack   = (state_q == StAck);
  assign busy  = (state_q != StIdle);

endmodule
